// File: rtl/game_pkg.sv
// Shared types and helpers for the brick-breaker score/lives controller.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE     = 2'd1,
        PLAY      = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    typedef logic [3:0] bcd_t;

    localparam int MAX_LIFES = 3;

    function automatic logic [31:0] bcd3_to_bin(input logic [11:0] bcd);
        return {28'd0, bcd[11:8]} * 32'd100
             + {28'd0, bcd[7:4]}  * 32'd10
             + {28'd0, bcd[3:0]};
    endfunction

endpackage

// File: rtl/game_score_ctrl_bcd_digit_add.sv
// Single BCD digit adder with carry in/out; chained three deep for the score.
module bcd_digit_add
    import game_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    output bcd_t sum,
    output logic cout
);

    logic [4:0] raw;
    logic [4:0] raw_adj;

    always_comb begin
        raw     = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        raw_adj = raw - 5'd10;
        if (raw > 5'd9) begin
            sum  = raw_adj[3:0];
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/game_score_ctrl.sv
// Score, lives and game-phase controller for the brick-breaker game.
// Optional macro GAME_SCORE_BONUS_LIFE_EN awards a life on each hundreds-digit increment.
module game_score_ctrl
    import game_pkg::*;
#(
    parameter int SERVE_DELAY = 50_000_000,
    parameter int START_LIFES = 3,
    parameter int SCORE_MAX   = 999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        brick_hit,
    input  logic [1:0]  brick_value,
    input  logic        ball_lost,
    output int          points,
    output int          lifes,
    output logic [11:0] score_bcd,
    output logic        ball_hold,
    output logic        game_over
);

    localparam logic [31:0] TIMER_LOAD  = SERVE_DELAY;
    localparam logic [31:0] SCORE_MAX_U = SCORE_MAX;
    localparam logic [11:0] MAX_BCD     = {4'(SCORE_MAX / 100),
                                           4'((SCORE_MAX / 10) % 10),
                                           4'(SCORE_MAX % 10)};

    game_state_t state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [11:0] score_q, score_d;
    logic [1:0]  lifes_q, lifes_d;
    logic        ball_hold_q, ball_hold_d;
    logic        game_over_q, game_over_d;

    bcd_t        sum_u, sum_t, sum_h;
    logic        c_u, c_t, c_h;
    logic [11:0] sum_bcd;
    logic        sat;
    logic        bonus;
    logic [1:0]  lifes_after;

    bcd_digit_add u_add_units (
        .a    (score_q[3:0]),
        .b    ({2'b00, brick_value}),
        .cin  (1'b0),
        .sum  (sum_u),
        .cout (c_u)
    );

    bcd_digit_add u_add_tens (
        .a    (score_q[7:4]),
        .b    (4'd0),
        .cin  (c_u),
        .sum  (sum_t),
        .cout (c_t)
    );

    bcd_digit_add u_add_hundreds (
        .a    (score_q[11:8]),
        .b    (4'd0),
        .cin  (c_t),
        .sum  (sum_h),
        .cout (c_h)
    );

    assign sum_bcd = {sum_h, sum_t, sum_u};
    // A carry out of the hundreds digit means the sum passed 999 and must saturate too.
    assign sat     = c_h || (bcd3_to_bin(sum_bcd) > SCORE_MAX_U);

`ifdef GAME_SCORE_BONUS_LIFE_EN
    assign bonus = c_t && !sat && (lifes_q < 2'(MAX_LIFES));
`else
    assign bonus = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            score_q     <= '0;
            lifes_q     <= '0;
            ball_hold_q <= 1'b1;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            score_q     <= score_d;
            lifes_q     <= lifes_d;
            ball_hold_q <= ball_hold_d;
            game_over_q <= game_over_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        score_d     = score_q;
        lifes_d     = lifes_q;
        lifes_after = lifes_q;
        case (state_q)
            IDLE, GAME_OVER: begin
                if (start) begin
                    state_d = SERVE;
                    score_d = '0;
                    lifes_d = 2'(START_LIFES);
                    timer_d = TIMER_LOAD;
                end
            end
            SERVE: begin
                if (timer_q == '0) begin
                    state_d = PLAY;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            PLAY: begin
                // Score (and any bonus life) lands before a simultaneous lost ball is charged.
                if (brick_hit) begin
                    score_d     = sat ? MAX_BCD : sum_bcd;
                    lifes_after = lifes_q + {1'b0, bonus};
                end
                if (ball_lost) begin
                    if (lifes_after > 2'd1) begin
                        lifes_after = lifes_after - 2'd1;
                        timer_d     = TIMER_LOAD;
                        state_d     = SERVE;
                    end else begin
                        lifes_after = 2'd0;
                        state_d     = GAME_OVER;
                    end
                end
                lifes_d = lifes_after;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ball_hold_d = (state_d != PLAY);
        game_over_d = (state_d == GAME_OVER);
    end

    assign points    = bcd3_to_bin(score_q);
    assign lifes     = {30'd0, lifes_q};
    assign score_bcd = score_q;
    assign ball_hold = ball_hold_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Bench for game_score_ctrl: vector table, directed corner sequences and random play vs. a reference model.
module tb_game_score_ctrl;

    localparam int SD = 4;
    localparam int SL = 3;
    localparam int SM = 999;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        brick_hit;
    logic [1:0]  brick_value;
    logic        ball_lost;
    int          points;
    int          lifes;
    logic [11:0] score_bcd;
    logic        ball_hold;
    logic        game_over;

    game_score_ctrl #(
        .SERVE_DELAY (SD),
        .START_LIFES (SL),
        .SCORE_MAX   (SM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .brick_hit   (brick_hit),
        .brick_value (brick_value),
        .ball_lost   (ball_lost),
        .points      (points),
        .lifes       (lifes),
        .score_bcd   (score_bcd),
        .ball_hold   (ball_hold),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0=idle 1=serve 2=play 3=over, score as a plain integer.
    int m_phase, m_score, m_lifes, m_timer;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_score = 0;
        m_lifes = 0;
        m_timer = 0;
    endtask

    task automatic model_step(input logic s, input logic h, input int v, input logic l);
        int raw;
        case (m_phase)
            0, 3: if (s) begin
                m_phase = 1;
                m_score = 0;
                m_lifes = SL;
                m_timer = SD;
            end
            1: if (m_timer == 0) m_phase = 2; else m_timer--;
            default: begin
                if (h) begin
                    raw = m_score + v;
                    if (raw > SM) begin
                        m_score = SM;
                    end else begin
`ifdef GAME_SCORE_BONUS_LIFE_EN
                        if ((raw / 100) > (m_score / 100) && m_lifes < 3) m_lifes++;
`endif
                        m_score = raw;
                    end
                end
                if (l) begin
                    if (m_lifes > 1) begin
                        m_lifes--;
                        m_timer = SD;
                        m_phase = 1;
                    end else begin
                        m_lifes = 0;
                        m_phase = 3;
                    end
                end
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        logic [11:0] exp_bcd;
        exp_bcd = {4'(m_score / 100), 4'((m_score / 10) % 10), 4'(m_score % 10)};
        chk({tag, "_points"}, points, m_score);
        chk({tag, "_bcd"}, {20'd0, score_bcd}, {20'd0, exp_bcd});
        chk({tag, "_lifes"}, lifes, m_lifes);
        chk({tag, "_hold"}, {31'd0, ball_hold}, (m_phase != 2) ? 32'd1 : 32'd0);
        chk({tag, "_over"}, {31'd0, game_over}, (m_phase == 3) ? 32'd1 : 32'd0);
    endtask

    task automatic step(input logic s, input logic h, input logic [1:0] v, input logic l);
        @(negedge clk);
        start       = s;
        brick_hit   = h;
        brick_value = v;
        ball_lost   = l;
        @(posedge clk);
        model_step(s, h, int'(v), l);
        #1;
        check_model("model");
    endtask

    task automatic serve_out();
        repeat (SD + 1) step(1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    typedef struct {
        logic       s;
        logic       h;
        logic [1:0] v;
        logic       l;
        int         pts;
        int         lf;
        logic       hold;
        logic       over;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Idle lost ball, start, four serve cycles with ignored hits, into play, scoring, lost ball.
        tbl[0] = '{1'b0, 1'b0, 2'd0, 1'b1, 0, 0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 2'd0, 1'b0, 0, 3, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 2'd3, 1'b0, 0, 3, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 2'd2, 1'b0, 0, 3, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 2'd0, 1'b1, 0, 3, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 2'd1, 1'b0, 0, 3, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 2'd0, 1'b0, 0, 3, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 2'd3, 1'b0, 3, 3, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 2'd2, 1'b0, 5, 3, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 2'd0, 1'b1, 5, 2, 1'b1, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        brick_hit = 1'b0;
        brick_value = 2'd0;
        ball_lost = 1'b0;
        model_reset();
        #12;
        chk("reset_points", points, 0);
        chk("reset_bcd", {20'd0, score_bcd}, 32'h000);
        chk("reset_lifes", lifes, 0);
        chk("reset_hold", {31'd0, ball_hold}, 1);
        chk("reset_over", {31'd0, game_over}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].s, tbl[i].h, tbl[i].v, tbl[i].l);
            chk($sformatf("tbl%0d_points", i), points, tbl[i].pts);
            chk($sformatf("tbl%0d_lifes", i), lifes, tbl[i].lf);
            chk($sformatf("tbl%0d_hold", i), {31'd0, ball_hold}, {31'd0, tbl[i].hold});
            chk($sformatf("tbl%0d_over", i), {31'd0, game_over}, {31'd0, tbl[i].over});
        end

        // Hundreds-digit carry from 98.
        serve_out();
        chk("serve_release_hold", {31'd0, ball_hold}, 0);
        repeat (31) step(1'b0, 1'b1, 2'd3, 1'b0);
        chk("score98_bcd", {20'd0, score_bcd}, 32'h098);
        step(1'b0, 1'b1, 2'd3, 1'b0);
        chk("carry_bcd", {20'd0, score_bcd}, 32'h101);
        chk("carry_points", points, 101);
`ifdef GAME_SCORE_BONUS_LIFE_EN
        chk("carry_lifes", lifes, 3);
`else
        chk("carry_lifes", lifes, 2);
`endif

        // Last life lost together with a hit.
        for (int k = 0; k < 3 && m_lifes > 1; k++) begin
            step(1'b0, 1'b0, 2'd0, 1'b1);
            serve_out();
        end
        chk("last_life", lifes, 1);
        step(1'b0, 1'b1, 2'd2, 1'b1);
        chk("simul_points", points, 103);
        chk("simul_lifes", lifes, 0);
        chk("simul_over", {31'd0, game_over}, 1);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        chk("restart_lifes", lifes, 3);
        chk("restart_points", points, 0);
        chk("restart_over", {31'd0, game_over}, 0);

        // Saturation at 999.
        serve_out();
        repeat (332) step(1'b0, 1'b1, 2'd3, 1'b0);
        step(1'b0, 1'b1, 2'd2, 1'b0);
        chk("score998", points, 998);
        step(1'b0, 1'b1, 2'd3, 1'b0);
        chk("sat_points", points, 999);
        step(1'b0, 1'b1, 2'd1, 1'b0);
        chk("sat_hold_points", points, 999);
        chk("sat_bcd", {20'd0, score_bcd}, 32'h999);

        // Asynchronous reset mid-play at score 250.
        @(negedge clk);
        rst = 1'b1;
        brick_hit = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 2'd0, 1'b0);
        serve_out();
        repeat (83) step(1'b0, 1'b1, 2'd3, 1'b0);
        step(1'b0, 1'b1, 2'd1, 1'b0);
        chk("pre_rst_points", points, 250);
        @(negedge clk);
        start = 1'b0;
        brick_hit = 1'b0;
        ball_lost = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_points", points, 0);
        chk("async_rst_bcd", {20'd0, score_bcd}, 32'h000);
        chk("async_rst_lifes", lifes, 0);
        chk("async_rst_hold", {31'd0, ball_hold}, 1);
        chk("async_rst_over", {31'd0, game_over}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random play against the model.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 1) == 1),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 29) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_score_ctrl.md
# game_score_ctrl

Score and lives controller for the brick-breaker game. Consumes single-cycle game events from the playfield logic (brick hit, ball lost, start), keeps the score as three BCD digits and the lives count, and sequences the game phases (idle, serve, play, game over). Its `points` and `lifes` outputs drive the seven-segment status display directly; `ball_hold` tells the ball logic when to freeze the ball for a re-serve.

## Interface
Parameters:
- `SERVE_DELAY`, default 50_000_000: cycles the ball is held after start or after a lost ball.
- `START_LIFES`, default 3: lives loaded at game start; legal range 1..3.
- `SCORE_MAX`, default 999: score saturation value.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `start`  in  1  one-cycle pulse; starts a new game
- `brick_hit`  in  1  one-cycle pulse; a brick was destroyed
- `brick_value`  in  2  points for this hit, sampled with `brick_hit`; 0 means 0 points
- `ball_lost`  in  1  one-cycle pulse; ball left the playfield
- `points`  out  int  binary score 0..999, derived from the BCD digits
- `lifes`  out  int  lives remaining, 0..3
- `score_bcd`  out  12  {hundreds, tens, units} BCD digits
- `ball_hold`  out  1  ball frozen at the paddle
- `game_over`  out  1  high in GAME_OVER

## Operation
- FSM states:
  - IDLE: `ball_hold`=1. `start` → SERVE, with score cleared, `lifes`=START_LIFES and the timer loaded.
  - SERVE: `ball_hold`=1; the timer counts down. At timer==0 → PLAY.
  - PLAY: `ball_hold`=0.
    - `ball_lost` with `lifes`>1 → decrement `lifes`, reload the timer, → SERVE.
    - `ball_lost` with `lifes`==1 → `lifes`=0, → GAME_OVER.
  - GAME_OVER: `game_over`=1, `ball_hold`=1. `start` → same actions as from IDLE.
- Scoring:
  - `brick_hit` is accepted only in PLAY and adds `brick_value` (0..3) to the score.
  - BCD add with per-digit carry: units, then tens, then hundreds.
  - If the sum exceeds SCORE_MAX, the score saturates at SCORE_MAX; there is no wrap.
- `points` = hundreds*100 + tens*10 + units, computed combinationally from the registered digits.
- Events outside their legal state are ignored: `brick_hit` outside PLAY, `ball_lost` outside PLAY, `start` in SERVE or PLAY.
- Simultaneous events in PLAY in the same cycle:
  - `brick_hit` and `ball_lost`: the score is added first, then the lost life is applied; both take effect in the same cycle.
  - `start` has no effect in PLAY.

## Timing
- Reset values: state IDLE, `points`=0, `score_bcd`=12'h000, `lifes`=0, `ball_hold`=1, `game_over`=0, timer 0.
- All outputs are registered except `points`, which is combinational from `score_bcd`.
- Latency: an event pulse at edge N is reflected on the outputs after edge N (one cycle).
- SERVE lasts exactly SERVE_DELAY+1 cycles: the timer loads SERVE_DELAY and leaves SERVE at 0.
- Reset asserted mid-game returns the block to IDLE immediately and asynchronously, with all reset values.

## Configuration
- Macro `GAME_SCORE_BONUS_LIFE_EN`.
- Defined: when the hundreds digit increments and `lifes`<3, `lifes` increments in the same cycle as the score update.
  - At `lifes`==3 no life is awarded.
  - Saturation at 999 does not award a life.
- Undefined: lives change only through start and `ball_lost`.

## Structure
- Package `game_pkg` holds:
  - `game_state_t` enum {IDLE, SERVE, PLAY, GAME_OVER};
  - `bcd_t` (logic [3:0]);
  - constant `MAX_LIFES`=3.
- Sub-module `bcd_digit_add`: one BCD digit plus carry-in, producing a digit and carry-out. Three are chained for the score adder.
- The saturation compare and the FSM stay in the top level.

## Test plan
- Reset, then `start`: after SERVE_DELAY+1 cycles, `ball_hold`=0, `lifes`=3, `points`=0.
- Score 98 (`score_bcd`=12'h098), `brick_hit` with value 3: `score_bcd`=12'h101, `points`=101.
  - With the macro and `lifes`=2: `lifes`=3.
  - Without the macro: `lifes` stays 2.
- Score 998, hit value 3: `points`=999. A further hit with value 1 keeps `points`=999.
- `lifes`=1, `ball_lost` in the same cycle as a value-2 hit: `points` increases by 2, `lifes`=0, `game_over`=1. A subsequent `start` gives `lifes`=3, `points`=0.
- `brick_hit` during SERVE and `ball_lost` during IDLE: no output changes.
- `rst` pulsed mid-PLAY with score 250: outputs return to reset values asynchronously, before the next clock edge.
